// File: rtl/icache_pkg.sv
// Shared types and sizes for the direct-mapped instruction cache.
package icache_pkg;

  localparam int IWORD_W = 32;
  localparam int ISETS   = 16;
  localparam int IIDX_W  = $clog2(ISETS);
  localparam int ITAG_W  = IWORD_W - IIDX_W - 2;

  // Fetch address split into tag / frame index / byte offset.
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  // One cache frame: a single instruction word.
  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [IWORD_W-1:0] data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of one instruction cache instance.
interface icache_if #(
  parameter int WORD_W = 32
);
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;
  logic              ihit;
  logic [WORD_W-1:0] imemload;
  logic              iflush;
  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              iwait;
  logic [WORD_W-1:0] iload;

  // The cache itself.
  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  // The datapath fetch stage together with the memory controller port.
  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_frames.sv
// Frame storage: one synchronous write port, one combinational read port,
// and a clear-all that only touches the valid bits.
module icache_frames #(
  parameter  int WORD_W = 32,
  parameter  int SETS   = 16,
  localparam int IDX_W  = $clog2(SETS),
  localparam int TAG_W  = WORD_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [TAG_W-1:0]  wtag,
  input  logic [WORD_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic              rvalid,
  output logic [TAG_W-1:0]  rtag,
  output logic [WORD_W-1:0] rdata
);

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags [SETS];
  logic [WORD_W-1:0] words [SETS];

  // Valid bits: clear-all wins over a fill.
  always_ff @(posedge clk) begin
    if (clr) begin
      valid <= '0;
    end else if (we) begin
      valid[widx] <= 1'b1;
    end
  end

  // Tag and data are never reset; they only matter once valid is set.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[widx]  <= wtag;
      words[widx] <= wdata;
    end
  end

  assign rvalid = valid[ridx];
  assign rtag   = tags[ridx];
  assign rdata  = words[ridx];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit path plus a
// two-state fill FSM towards the memory controller's instruction port.
module icache
  import icache_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int SETS   = 16
) (
  input logic     CLK,
  input logic     RST,
  icache_if.slave bus
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = WORD_W - IDX_W - 2;

  icache_state_t     state;
  logic [WORD_W-3:0] missaddr;
  logic              ren_q;
  logic [WORD_W-1:0] iaddr_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              rvalid;
  logic [TAG_W-1:0]  rtag;
  logic [WORD_W-1:0] rdata;
  logic              hit;
  logic              fill_we;
  logic              unused_offset;

  assign req_idx       = bus.imemaddr[IDX_W+1:2];
  assign req_tag       = bus.imemaddr[WORD_W-1:IDX_W+2];
  assign unused_offset = ^bus.imemaddr[1:0];

  // Lookups are only answered while idle and never during a flush cycle.
  assign hit = bus.imemREN & rvalid & (rtag == req_tag) & (state == IDLE) & ~bus.iflush;

  // A fill lands only on the cycle memory answers, unless reset or flush overrides it.
  assign fill_we = (state == FETCH) & ~bus.iwait & ~bus.iflush & ~RST;

  icache_frames #(
    .WORD_W (WORD_W),
    .SETS   (SETS)
  ) u_frames (
    .clk    (CLK),
    .clr    (RST | bus.iflush),
    .we     (fill_we),
    .widx   (missaddr[IDX_W-1:0]),
    .wtag   (missaddr[WORD_W-3:IDX_W]),
    .wdata  (bus.iload),
    .ridx   (req_idx),
    .rvalid (rvalid),
    .rtag   (rtag),
    .rdata  (rdata)
  );

  // Fill FSM with registered memory-side request; a started fill is never cancelled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      missaddr <= '0;
      ren_q    <= 1'b0;
      iaddr_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.imemREN && !hit && !bus.iflush) begin
            missaddr <= bus.imemaddr[WORD_W-1:2];
            ren_q    <= 1'b1;
            iaddr_q  <= {bus.imemaddr[WORD_W-1:2], 2'b00};
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (!bus.iwait) begin
            ren_q   <= 1'b0;
            iaddr_q <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          ren_q   <= 1'b0;
          iaddr_q <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.ihit     = hit;
  assign bus.imemload = hit ? rdata : '0;
  assign bus.iREN     = ren_q;
  assign bus.iaddr    = iaddr_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus a randomized run
// against a tag/valid/data reference model of a direct-mapped cache.
module tb_icache;
  import icache_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  icache_if bus ();

  icache dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  bit                m_valid [ISETS];
  logic [ITAG_W-1:0] m_tag   [ISETS];
  logic [31:0]       m_data  [ISETS];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One fetch: request, and if it misses, serve the fill after 'waits' busy cycles.
  task automatic access(input logic [31:0] addr, input int waits, input logic [31:0] data,
                        output logic first_hit, output logic [31:0] first_load,
                        output logic fetch_ok, output logic hit_after,
                        output logic [31:0] load_after);
    tick();
    bus.imemREN  = 1'b1;
    bus.imemaddr = addr;
    bus.iflush   = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    #1;
    first_hit  = bus.ihit;
    first_load = bus.imemload;
    fetch_ok   = 1'b1;
    hit_after  = 1'b0;
    load_after = '0;
    if (first_hit !== 1'b1) begin
      for (int k = 0; k <= waits; k++) begin
        tick();
        bus.iwait = (k < waits);
        bus.iload = data;
        #1;
        if (!(bus.iREN === 1'b1 && bus.iaddr === {addr[31:2], 2'b00} && bus.ihit === 1'b0))
          fetch_ok = 1'b0;
      end
      tick();
      bus.iwait = 1'b1;
      bus.iload = '0;
      #1;
      hit_after  = bus.ihit;
      load_after = bus.imemload;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.imemREN = 1'b0; bus.imemaddr = '0; bus.iflush = 1'b0; bus.iwait = 1'b1; bus.iload = '0;
    tick();
    tick();
    RST = 1'b0;
    bus.imemREN = 1'b1;
    bus.imemaddr = 32'h0000_0000;
    #1;
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL reset_ihit got=%b want=0", bus.ihit); end
    total++; if (bus.imemload !== 32'h0) begin bad++; $display("FAIL reset_imemload got=%h want=0", bus.imemload); end
    total++; if (bus.iREN !== 1'b0) begin bad++; $display("FAIL reset_iREN got=%b want=0", bus.iREN); end
    total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL reset_iaddr got=%h want=0", bus.iaddr); end
    tick();
    #1;
    total++; if (bus.iREN !== 1'b1) begin bad++; $display("FAIL reset_miss_iREN got=%b want=1", bus.iREN); end
    total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL reset_miss_iaddr got=%h want=0", bus.iaddr); end
    tick();
    bus.iwait = 1'b0;
    bus.iload = 32'h0000_1000;
    #1;
    tick();
    bus.iwait = 1'b1;
    #1;
    total++; if (bus.ihit !== 1'b1) begin bad++; $display("FAIL reset_fill_hit got=%b want=1", bus.ihit); end
    total++; if (bus.imemload !== 32'h0000_1000) begin bad++; $display("FAIL reset_fill_data got=%h want=00001000", bus.imemload); end
  endtask

  task automatic test_cold_miss();
    logic fh, fok, ha;
    logic [31:0] fl, la;
    access(32'h0000_0044, 3, 32'hDEAD_BEEF, fh, fl, fok, ha, la);
    total++; if (fh !== 1'b0) begin bad++; $display("FAIL cold_first got=%b want=0", fh); end
    total++; if (fok !== 1'b1) begin bad++; $display("FAIL cold_fetch got=%b want=1", fok); end
    total++; if (ha !== 1'b1) begin bad++; $display("FAIL cold_hit got=%b want=1", ha); end
    total++; if (la !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cold_data got=%h want=deadbeef", la); end
  endtask

  task automatic test_conflict();
    logic fh, fok, ha;
    logic [31:0] fl, la;
    access(32'h0000_0004, 1, 32'hAAAA_0004, fh, fl, fok, ha, la);
    total++; if (fh !== 1'b0) begin bad++; $display("FAIL conf_evict_first got=%b want=0", fh); end
    total++; if (la !== 32'hAAAA_0004) begin bad++; $display("FAIL conf_fill4 got=%h want=aaaa0004", la); end
    access(32'h0000_0004, 0, 32'h0, fh, fl, fok, ha, la);
    total++; if (fh !== 1'b1) begin bad++; $display("FAIL conf_rehit got=%b want=1", fh); end
    total++; if (fl !== 32'hAAAA_0004) begin bad++; $display("FAIL conf_rehit_data got=%h want=aaaa0004", fl); end
    access(32'h0000_0044, 0, 32'h1111_1111, fh, fl, fok, ha, la);
    total++; if (fh !== 1'b0) begin bad++; $display("FAIL conf_44_first got=%b want=0", fh); end
    total++; if (la !== 32'h1111_1111) begin bad++; $display("FAIL conf_44_data got=%h want=11111111", la); end
    access(32'h0000_0004, 2, 32'h2222_2222, fh, fl, fok, ha, la);
    total++; if (fh !== 1'b0) begin bad++; $display("FAIL conf_4_again got=%b want=0", fh); end
    total++; if (fok !== 1'b1) begin bad++; $display("FAIL conf_4_fetch got=%b want=1", fok); end
    total++; if (la !== 32'h2222_2222) begin bad++; $display("FAIL conf_4_data got=%h want=22222222", la); end
  endtask

  task automatic test_addr_change();
    logic fh, fok, ha;
    logic [31:0] fl, la;
    tick();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0008; bus.iwait = 1'b1;
    #1;
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL chg_first got=%b want=0", bus.ihit); end
    tick();
    bus.imemaddr = 32'h0000_000C;
    #1;
    total++; if (bus.iaddr !== 32'h0000_0008) begin bad++; $display("FAIL chg_iaddr got=%h want=00000008", bus.iaddr); end
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL chg_fetch_ihit got=%b want=0", bus.ihit); end
    tick();
    bus.iwait = 1'b0; bus.iload = 32'h8888_8888;
    #1;
    total++; if (bus.iaddr !== 32'h0000_0008) begin bad++; $display("FAIL chg_iaddr_last got=%h want=00000008", bus.iaddr); end
    tick();
    bus.iwait = 1'b1;
    #1;
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL chg_c_miss got=%b want=0", bus.ihit); end
    tick();
    bus.iwait = 1'b0; bus.iload = 32'hCCCC_CCCC;
    #1;
    total++; if (bus.iaddr !== 32'h0000_000C) begin bad++; $display("FAIL chg_c_iaddr got=%h want=0000000c", bus.iaddr); end
    tick();
    bus.iwait = 1'b1;
    #1;
    total++; if (bus.imemload !== 32'hCCCC_CCCC) begin bad++; $display("FAIL chg_c_data got=%h want=cccccccc", bus.imemload); end
    access(32'h0000_0008, 0, 32'h0, fh, fl, fok, ha, la);
    total++; if (fh !== 1'b1) begin bad++; $display("FAIL chg_8_hit got=%b want=1", fh); end
    total++; if (fl !== 32'h8888_8888) begin bad++; $display("FAIL chg_8_data got=%h want=88888888", fl); end
  endtask

  task automatic test_flush();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h0000_1000; exp_w[1] = 32'h2222_2222;
    exp_w[2] = 32'h8888_8888; exp_w[3] = 32'hCCCC_CCCC;
    tick();
    bus.imemREN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.imemaddr = 32'(i * 4);
      #1;
      total++; if (bus.imemload !== exp_w[i]) begin bad++; $display("FAIL flush_pre%0d got=%h want=%h", i, bus.imemload, exp_w[i]); end
    end
    tick();
    bus.iflush = 1'b1; bus.imemaddr = 32'h0;
    #1;
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL flush_cycle_ihit got=%b want=0", bus.ihit); end
    tick();
    bus.iflush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.imemaddr = 32'(i * 4);
      #1;
      total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL flush_post%0d got=%b want=0", i, bus.ihit); end
    end
    bus.imemREN = 1'b0;
    // flush on the same edge as the fill completes
    tick();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0010; bus.iwait = 1'b1;
    #1;
    tick();
    bus.iwait = 1'b0; bus.iload = 32'h4444_4444; bus.iflush = 1'b1;
    #1;
    total++; if (bus.iREN !== 1'b1) begin bad++; $display("FAIL flushfill_iREN got=%b want=1", bus.iREN); end
    tick();
    bus.iflush = 1'b0; bus.iwait = 1'b1;
    #1;
    total++; if (bus.iREN !== 1'b0) begin bad++; $display("FAIL flushfill_idle got=%b want=0", bus.iREN); end
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL flushfill_invalid got=%b want=0", bus.ihit); end
    tick();
    #1;
    total++; if (bus.iaddr !== 32'h0000_0010) begin bad++; $display("FAIL flushfill_refetch got=%h want=00000010", bus.iaddr); end
    tick();
    bus.iwait = 1'b0; bus.iload = 32'h4545_4545;
    #1;
    tick();
    bus.iwait = 1'b1;
    #1;
    total++; if (bus.imemload !== 32'h4545_4545) begin bad++; $display("FAIL flushfill_data got=%h want=45454545", bus.imemload); end
    // flush while memory is still busy: the fill carries on
    tick();
    bus.imemaddr = 32'h0000_0014;
    #1;
    tick();
    bus.iflush = 1'b1;
    #1;
    tick();
    bus.iflush = 1'b0; bus.iwait = 1'b0; bus.iload = 32'h5555_5555;
    #1;
    total++; if (bus.iREN !== 1'b1) begin bad++; $display("FAIL flushbusy_iREN got=%b want=1", bus.iREN); end
    tick();
    bus.iwait = 1'b1;
    #1;
    total++; if (bus.ihit !== 1'b1) begin bad++; $display("FAIL flushbusy_hit got=%b want=1", bus.ihit); end
    total++; if (bus.imemload !== 32'h5555_5555) begin bad++; $display("FAIL flushbusy_data got=%h want=55555555", bus.imemload); end
    bus.imemREN = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    tick();
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0000_0020; bus.iwait = 1'b1;
    #1;
    tick();
    bus.iwait = 1'b0; bus.iload = 32'hCAFE_F00D; RST = 1'b1;
    #1;
    tick();
    RST = 1'b0; bus.iwait = 1'b1;
    #1;
    total++; if (bus.iREN !== 1'b0) begin bad++; $display("FAIL rstfill_iREN got=%b want=0", bus.iREN); end
    total++; if (bus.iaddr !== 32'h0) begin bad++; $display("FAIL rstfill_iaddr got=%h want=0", bus.iaddr); end
    total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL rstfill_nohit got=%b want=0", bus.ihit); end
    tick();
    #1;
    total++; if (bus.iaddr !== 32'h0000_0020) begin bad++; $display("FAIL rstfill_refetch got=%h want=00000020", bus.iaddr); end
    tick();
    bus.iwait = 1'b0; bus.iload = 32'h2020_2020;
    #1;
    tick();
    bus.iwait = 1'b1; bus.imemREN = 1'b0;
    #1;
  endtask

  task automatic test_random();
    logic fh, fok, ha;
    logic [31:0] fl, la, addr, data;
    logic [31:0] bases [3];
    icachef_t f;
    logic exp_hit;
    int waits;
    bases[0] = 32'h0000_0000; bases[1] = 32'h0000_0040; bases[2] = 32'h1234_0000;
    tick();
    bus.imemREN = 1'b0; bus.iflush = 1'b1;
    #1;
    for (int i = 0; i < ISETS; i++) m_valid[i] = 1'b0;
    for (int it = 0; it < 200; it++) begin
      addr = bases[$urandom_range(0, 2)] | (32'($urandom_range(0, ISETS - 1)) << 2)
             | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        tick();
        bus.imemREN = 1'b1; bus.imemaddr = addr; bus.iflush = 1'b1; bus.iwait = 1'b1;
        #1;
        total++; if (bus.ihit !== 1'b0) begin bad++; $display("FAIL rnd_flush_ihit it=%0d got=%b want=0", it, bus.ihit); end
        for (int i = 0; i < ISETS; i++) m_valid[i] = 1'b0;
      end
      f = addr;
      exp_hit = m_valid[f.idx] && (m_tag[f.idx] == f.tag);
      data  = $urandom;
      waits = $urandom_range(0, 3);
      access(addr, waits, data, fh, fl, fok, ha, la);
      total++; if (fh !== exp_hit) begin bad++; $display("FAIL rnd_hit it=%0d addr=%h got=%b want=%b", it, addr, fh, exp_hit); end
      if (exp_hit) begin
        total++; if (fl !== m_data[f.idx]) begin bad++; $display("FAIL rnd_hitdata it=%0d got=%h want=%h", it, fl, m_data[f.idx]); end
      end else begin
        total++; if (fok !== 1'b1) begin bad++; $display("FAIL rnd_fetch it=%0d got=%b want=1", it, fok); end
        total++; if (la !== data) begin bad++; $display("FAIL rnd_fill it=%0d got=%h want=%h", it, la, data); end
        m_valid[f.idx] = 1'b1;
        m_tag[f.idx]   = f.tag;
        m_data[f.idx]  = data;
      end
    end
    tick();
    bus.imemREN = 1'b0; bus.iflush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_addr_change();
    test_flush();
    test_reset_mid_fill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache between the datapath fetch stage and the memory controller's per-CPU instruction port.
- Hits are served combinationally in the request cycle.
- Misses go through a two-state fill FSM that drives iREN/iaddr and waits for iwait to drop before writing the frame.
- One instance per CPU; its memory-side ports connect to element [n] of the cache-control interface's iREN/iaddr/iwait/iload arrays.

Parameters:
- WORD_W, 32, data and address width.
- SETS, 16, number of one-word frames; power of two, index = log2(SETS) bits.

Ports:
- CLK  input  1  clock, all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- imemREN  input  1  datapath fetch request.
- imemaddr  input  WORD_W  fetch byte address; bits [1:0] ignored.
- ihit  output  1  imemload valid this cycle.
- imemload  output  WORD_W  instruction word.
- iflush  input  1  one-cycle pulse that invalidates all frames.
- iREN  output  1  read request to memory controller.
- iaddr  output  WORD_W  word-aligned fill address.
- iwait  input  1  memory controller busy; 0 means iload is valid this cycle.
- iload  input  WORD_W  fill data.

Behaviour:
- Address split:
  - byte offset [1:0]
  - index [IDX+1:2], where IDX = log2(SETS)
  - tag [WORD_W-1:IDX+2], 26 bits at the defaults.
- Frame contents: valid bit, tag, data word. Only valid bits are reset; tag and data are don't-care after reset.
- Reset (RST=1 at an edge):
  - all valid bits cleared; FSM returns to IDLE; miss-address register cleared to 0.
  - From the next cycle: iREN=0, iaddr=0, ihit=0, imemload=0 until a valid hit.
- Hit, combinational:
  - ihit = imemREN & valid[idx] & (tag[idx]==addr tag) & (state==IDLE) & ~iflush.
  - imemload = data[idx] when ihit, else 0.
- State IDLE:
  - iREN=0, iaddr=0.
  - On imemREN & ~hit & ~iflush: latch {imemaddr[WORD_W-1:2],2'b00} into missaddr and go to FETCH.
- State FETCH:
  - iREN=1, iaddr=missaddr. ihit=0 regardless of imemaddr.
  - When iwait==0: at the edge, write frame[missaddr.idx] <= {1, missaddr.tag, iload}, then go to IDLE.
  - While iwait==1: stay in FETCH with iREN held high.
- Miss latency: request cycle, then N FETCH cycles (the last with iwait=0), then a hit in the following IDLE cycle. Minimum 2 cycles from the miss to ihit.
- The fill always uses the latched missaddr. If imemaddr changes or imemREN drops during FETCH, the fill still completes, and the new address is looked up in IDLE afterwards. No cancel.
- iflush:
  - Clears all valid bits at the edge.
  - In FETCH on the same edge as iwait==0, the fill write is discarded, the frame stays invalid, and the FSM goes to IDLE.
  - In FETCH with iwait==1, the FSM stays in FETCH and the fill completes normally; this is a post-flush refetch.
  - ihit is forced 0 during the flush cycle.
- Conflict miss on the same index: the new frame overwrites the old one with no write-back, because the cache is read-only.
- RST during FETCH: the fill is abandoned, iREN is 0 from the next cycle, and no frame is written even if iwait==0 in the reset cycle.
- RST has priority over iflush, which has priority over fill, which has priority over lookup.

Decomposition:
- Add to cpu_types_pkg:
  - packed struct icachef_t {tag, idx, bytoff} sized from SETS=16.
  - packed struct icache_frame_t {valid, tag, data}.
  - enum icache_state_t {IDLE, FETCH}.
  - localparams ITAG_W and IIDX_W.
- Sub-module: icache_frames, the SETS-entry frame array. It has a synchronous write port, a combinational read port and a clear-all-valid input driven by RST|iflush. The FSM and hit logic stay in icache.

Test Plan:
- Reset: assert RST 2 cycles, then imemREN=1, imemaddr=0x0000_0000 -> ihit=0, iREN=1 next cycle, iaddr=0x0000_0000.
- Cold miss fill: addr 0x0000_0044, iwait=1 for 3 cycles then 0 with iload=0xDEAD_BEEF -> ihit=1 and imemload=0xDEAD_BEEF one cycle after iwait fell; total 5 cycles from request.
- Hit/conflict: fill 0x0000_0004 (idx 1), then request 0x0000_0044 (idx 1, different tag) -> miss, refill with 0x1111_1111; re-request 0x0000_0004 -> miss again.
- Address change mid-fetch: miss on 0x0000_0008, change imemaddr to 0x0000_000C during FETCH -> iaddr stays 0x0000_0008, frame 2 filled, then miss on 0x0000_000C.
- Flush: with frames 0..3 valid, pulse iflush -> ihit=0 on all four next cycle. iflush coincident with iwait=0 in FETCH -> frame remains invalid, FSM returns to IDLE.
- Reset mid-fill: RST during FETCH with iwait=0, iload=0xCAFE_F00D -> iREN=0 next cycle, and a subsequent request to the same address misses.
